// File: rtl/bhg_fifo_burst_packer.sv
// Packs single words popped from an FWFT FIFO into one wide burst with lane mask and word count.
// A partial burst leaves on flush or after an idle timeout, so sparse traffic never stalls here.
module bhg_fifo_burst_packer #(
  parameter int BITS            = 8,
  parameter int WORDS_PER_BURST = 4,
  parameter int FLUSH_TIMEOUT   = 16
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic                                 fifo_data_ready,
  input  logic [BITS-1:0]                      fifo_data_out,
  output logic                                 fifo_shift_out,
  input  logic                                 flush,
  output logic                                 burst_valid,
  input  logic                                 burst_ready,
  output logic [BITS*WORDS_PER_BURST-1:0]      burst_data,
  output logic [WORDS_PER_BURST-1:0]           burst_mask,
  output logic [$clog2(WORDS_PER_BURST+1)-1:0] burst_count
);

  localparam int CW = $clog2(WORDS_PER_BURST + 1);
  localparam int TW = (FLUSH_TIMEOUT > 0) ? $clog2(FLUSH_TIMEOUT + 1) : 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(WORDS_PER_BURST);
  localparam logic [TW-1:0] TO_VAL   = TW'(FLUSH_TIMEOUT);

  typedef enum logic {
    FILL = 1'b0,
    HOLD = 1'b1
  } state_t;

  state_t                           state_q, state_d;
  logic [CW-1:0]                    count_q, count_d;
  logic [TW-1:0]                    timer_q, timer_d;
  logic [BITS*WORDS_PER_BURST-1:0]  data_q, data_d;
  logic [WORDS_PER_BURST-1:0]       mask_q, mask_d;
  logic                             accept;
  logic                             timeout_hit;

  assign accept         = (state_q == FILL) && fifo_data_ready;
  assign fifo_shift_out = accept && !reset;

  always_comb begin
    state_d     = state_q;
    count_d     = count_q;
    timer_d     = timer_q;
    data_d      = data_q;
    mask_d      = mask_q;
    timeout_hit = 1'b0;
    case (state_q)
      FILL: begin
        if (accept) begin
          for (int k = 0; k < WORDS_PER_BURST; k++) begin
            if (count_q == CW'(k)) begin
              data_d[k*BITS +: BITS] = fifo_data_out;
              mask_d[k]              = 1'b1;
            end
          end
          count_d = count_q + CW'(1);
          timer_d = '0;
        end else if (count_q != '0 && timer_q != '1) begin
          timer_d = timer_q + TW'(1);
        end
        // Timer only runs while idle with a partial burst, so an accept can never time out.
        timeout_hit = (FLUSH_TIMEOUT != 0) && !accept && (count_q != '0) && (timer_d == TO_VAL);
        if ((count_d == FULL_CNT) || (flush && count_d != '0) || timeout_hit) begin
          state_d = HOLD;
          timer_d = '0;
        end
      end
      HOLD: begin
        if (burst_ready) begin
          state_d = FILL;
          count_d = '0;
          timer_d = '0;
          data_d  = '0;
          mask_d  = '0;
        end
      end
      default: state_d = FILL;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= FILL;
      count_q <= '0;
      timer_q <= '0;
      data_q  <= '0;
      mask_q  <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      timer_q <= timer_d;
      data_q  <= data_d;
      mask_q  <= mask_d;
    end
  end

  assign burst_valid = (state_q == HOLD);
  assign burst_data  = data_q;
  assign burst_mask  = mask_q;
  assign burst_count = count_q;

endmodule

// File: tb/tb_bhg_fifo_burst_packer.sv
// Directed bench for bhg_fifo_burst_packer: vector table plus hand-written reset sequence.
module tb_bhg_fifo_burst_packer;

  logic        clk;
  logic        reset;
  logic        fifo_data_ready;
  logic [7:0]  fifo_data_out;
  logic        fifo_shift_out;
  logic        flush;
  logic        burst_valid;
  logic        burst_ready;
  logic [31:0] burst_data;
  logic [3:0]  burst_mask;
  logic [2:0]  burst_count;

  int checks = 0;
  int errors = 0;

  bhg_fifo_burst_packer #(
    .BITS(8), .WORDS_PER_BURST(4), .FLUSH_TIMEOUT(4)
  ) dut (
    .clk(clk), .reset(reset),
    .fifo_data_ready(fifo_data_ready), .fifo_data_out(fifo_data_out),
    .fifo_shift_out(fifo_shift_out), .flush(flush),
    .burst_valid(burst_valid), .burst_ready(burst_ready),
    .burst_data(burst_data), .burst_mask(burst_mask), .burst_count(burst_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rdy;
    logic [7:0]  din;
    logic        fl;
    logic        brdy;
    logic        e_shift;
    logic        e_valid;
    logic [31:0] e_data;
    logic [3:0]  e_mask;
    logic [2:0]  e_count;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic rdy, input logic [7:0] din, input logic fl, input logic brdy,
                     input logic e_shift, input logic e_valid, input logic [31:0] e_data,
                     input logic [3:0] e_mask, input logic [2:0] e_count);
    vec_t v;
    v.rdy = rdy; v.din = din; v.fl = fl; v.brdy = brdy;
    v.e_shift = e_shift; v.e_valid = e_valid; v.e_data = e_data;
    v.e_mask = e_mask; v.e_count = e_count;
    vecs.push_back(v);
  endtask

  task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s (step %0d): got 0x%0h, expected 0x%0h", name, idx, act, exp);
    end
  endtask

  task automatic chk_all(input string tag, input int idx, input logic e_shift, input logic e_valid,
                         input logic [31:0] e_data, input logic [3:0] e_mask, input logic [2:0] e_count);
    chk({tag, ".shift_out"}, idx, 32'(fifo_shift_out), 32'(e_shift));
    chk({tag, ".valid"},     idx, 32'(burst_valid),    32'(e_valid));
    chk({tag, ".data"},      idx, burst_data,          e_data);
    chk({tag, ".mask"},      idx, 32'(burst_mask),     32'(e_mask));
    if (e_valid) chk({tag, ".count"}, idx, 32'(burst_count), 32'(e_count));
  endtask

  initial begin
    // Full burst back-to-back, handoff, then next pop right after
    add(1, 8'h11, 0, 1, 1, 0, 32'h0,        4'h0, 0);
    add(1, 8'h22, 0, 1, 1, 0, 32'h11,       4'h1, 1);
    add(1, 8'h33, 0, 1, 1, 0, 32'h2211,     4'h3, 2);
    add(1, 8'h44, 0, 1, 1, 0, 32'h332211,   4'h7, 3);
    add(1, 8'hAA, 0, 1, 0, 1, 32'h44332211, 4'hF, 4);
    // Backpressure: second full burst held for 5 cycles
    add(1, 8'h11, 0, 0, 1, 0, 32'h0,        4'h0, 0);
    add(1, 8'h22, 0, 0, 1, 0, 32'h11,       4'h1, 1);
    add(1, 8'h33, 0, 0, 1, 0, 32'h2211,     4'h3, 2);
    add(1, 8'h44, 0, 0, 1, 0, 32'h332211,   4'h7, 3);
    for (int i = 0; i < 5; i++) add(1, 8'h99, 1, 0, 0, 1, 32'h44332211, 4'hF, 4);
    add(1, 8'h99, 0, 1, 0, 1, 32'h44332211, 4'hF, 4);
    // Timeout with two words
    add(1, 8'hA1, 0, 1, 1, 0, 32'h0,        4'h0, 0);
    add(1, 8'hB2, 0, 1, 1, 0, 32'hA1,       4'h1, 1);
    for (int i = 0; i < 4; i++) add(0, 8'h00, 0, 1, 0, 0, 32'hB2A1, 4'h3, 2);
    add(0, 8'h00, 0, 1, 0, 1, 32'hB2A1,     4'h3, 2);
    // Flush on the edge of the third accept
    add(1, 8'h11, 0, 1, 1, 0, 32'h0,        4'h0, 0);
    add(1, 8'h22, 0, 1, 1, 0, 32'h11,       4'h1, 1);
    add(1, 8'h33, 1, 1, 1, 0, 32'h2211,     4'h3, 2);
    add(0, 8'h00, 0, 1, 0, 1, 32'h332211,   4'h7, 3);
    // Flush and idle with count=0 do nothing; next word goes to lane 0
    add(0, 8'h00, 1, 1, 0, 0, 32'h0,        4'h0, 0);
    add(0, 8'h00, 1, 1, 0, 0, 32'h0,        4'h0, 0);
    for (int i = 0; i < 6; i++) add(0, 8'h00, 0, 1, 0, 0, 32'h0, 4'h0, 0);
    add(1, 8'h77, 0, 1, 1, 0, 32'h0,        4'h0, 0);
    add(0, 8'h00, 1, 1, 0, 0, 32'h77,       4'h1, 1);
    add(0, 8'h00, 0, 1, 0, 1, 32'h77,       4'h1, 1);
    add(0, 8'h00, 0, 1, 0, 0, 32'h0,        4'h0, 0);

    reset = 1'b1;
    fifo_data_ready = 1'b1;
    fifo_data_out = 8'h5A;
    flush = 1'b0;
    burst_ready = 1'b1;
    #12;
    chk_all("reset", -1, 0, 0, 32'h0, 4'h0, 0);
    chk("reset.count", -1, 32'(burst_count), 32'h0);
    @(negedge clk);
    reset = 1'b0;
    fifo_data_ready = 1'b0;

    foreach (vecs[i]) begin
      @(negedge clk);
      fifo_data_ready = vecs[i].rdy;
      fifo_data_out   = vecs[i].din;
      flush           = vecs[i].fl;
      burst_ready     = vecs[i].brdy;
      #1;
      chk_all("vec", i, vecs[i].e_shift, vecs[i].e_valid, vecs[i].e_data, vecs[i].e_mask, vecs[i].e_count);
    end

    // Reset while holding a full burst: outputs clear without a clock edge
    @(negedge clk);
    burst_ready = 1'b0;
    flush = 1'b0;
    fifo_data_ready = 1'b1;
    fifo_data_out = 8'h11;
    @(negedge clk); fifo_data_out = 8'h22;
    @(negedge clk); fifo_data_out = 8'h33;
    @(negedge clk); fifo_data_out = 8'h44;
    @(negedge clk);
    #1;
    chk_all("hold_pre_reset", 0, 0, 1, 32'h44332211, 4'hF, 4);
    #1;
    reset = 1'b1;
    #1;
    chk_all("async_reset", 0, 0, 0, 32'h0, 4'h0, 0);
    chk("async_reset.count", 0, 32'(burst_count), 32'h0);
    @(negedge clk);
    reset = 1'b0;
    burst_ready = 1'b1;
    fifo_data_ready = 1'b1;
    fifo_data_out = 8'h55;
    flush = 1'b1;
    #1;
    chk("post_reset.shift_out", 0, 32'(fifo_shift_out), 32'h1);
    @(negedge clk);
    fifo_data_ready = 1'b0;
    flush = 1'b0;
    #1;
    chk_all("post_reset", 1, 0, 1, 32'h00000055, 4'h1, 1);
    @(negedge clk);
    #1;
    chk_all("post_reset_done", 2, 0, 0, 32'h0, 4'h0, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/bhg_fifo_burst_packer.md
Name: bhg_fifo_burst_packer

Overview:
- Downstream consumer of the FWFT shifter FIFOs.
- Pops single words through the FIFO's data_ready/shift_out/data_out interface.
- Packs them into one wide burst word for the DDR3 write-command path, with per-word lane mask and word count.
- A partial burst is emitted on an explicit flush or after an idle timeout, so sparse traffic never stalls inside the packer.

Parameters:
- BITS, 8, width of one FIFO word.
- WORDS_PER_BURST, 4, FIFO words packed per burst; 2 or more.
- FLUSH_TIMEOUT, 16, consecutive idle cycles with a partial burst before forced emission; 0 disables the timeout.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-high reset.
- fifo_data_ready  in  1  upstream FWFT FIFO holds a valid word.
- fifo_data_out  in  BITS  upstream FIFO head word.
- fifo_shift_out  out  1  pop strobe to upstream FIFO; combinational.
- flush  in  1  emit the current partial burst.
- burst_valid  out  1  burst outputs are valid.
- burst_ready  in  1  downstream accepts the burst.
- burst_data  out  BITS*WORDS_PER_BURST  packed words; word k occupies lanes [k*BITS +: BITS].
- burst_mask  out  WORDS_PER_BURST  bit k set when lane k holds a word.
- burst_count  out  $clog2(WORDS_PER_BURST+1)  number of valid words, 1..WORDS_PER_BURST.

Behaviour:
- Reset is asynchronous and active-high. While reset is asserted:
  - state=FILL, count=0, idle timer=0.
  - burst_valid=0, burst_data=0, burst_mask=0, burst_count=0.
  - fifo_shift_out is forced 0.
- States: FILL and HOLD.
- FILL:
  - fifo_shift_out = fifo_data_ready.
  - An accept is fifo_data_ready high on a clk edge in FILL. On an accept: fifo_data_out is written to lane[count], mask[count] is set, count increments, and the idle timer clears.
  - FILL to HOLD at the edge where any of these holds:
    - an accept makes count reach WORDS_PER_BURST;
    - flush is high and count after this edge's accept is at least 1;
    - FLUSH_TIMEOUT is nonzero, count is at least 1, and the idle timer reaches FLUSH_TIMEOUT.
  - A word accepted on the same edge as flush or timeout is included in the burst.
  - The idle timer increments only in FILL with count at least 1 and no accept; it saturates and clears when entering HOLD.
  - Flush or timer activity with count=0 has no effect.
- HOLD:
  - burst_valid=1. burst_data, burst_mask and burst_count are stable.
  - fifo_shift_out=0.
  - flush is ignored.
  - On burst_valid && burst_ready: return to FILL, count=0, burst_data and burst_mask cleared to 0, burst_valid low next cycle.
- Timing:
  - burst_valid rises the cycle after the completing accept.
  - Minimum one non-accepting cycle per burst, so a full burst takes WORDS_PER_BURST+1 cycles at best.
- Outputs:
  - Unused lanes always read 0.
  - burst_count equals the popcount of burst_mask.
  - burst_count and burst_mask are meaningful only while burst_valid=1.
- Each FIFO word is popped exactly once, in order; lane order equals arrival order.
- Reset mid-burst: the partial or held burst is discarded. burst_valid drops immediately without waiting for a clock edge. The next accepted word goes to lane 0.
- Backpressure: burst_ready low holds HOLD indefinitely, with no pops and no output change.

Test Plan:
All scenarios use BITS=8, WORDS_PER_BURST=4, FLUSH_TIMEOUT=4.
- Full burst: FIFO presents 0x11,0x22,0x33,0x44 back-to-back with burst_ready=1 -> 4 pops. burst_valid is high for 1 cycle, starting the cycle after the 4th pop, with burst_data=0x44332211, mask=4'b1111, count=4. The next pop follows the handoff.
- Backpressure: full burst with burst_ready=0 for 5 cycles and fifo_data_ready=1 -> fifo_shift_out=0 for all 5 cycles, outputs constant. When ready rises, burst is accepted and popping resumes the cycle after.
- Timeout: push 0xA1,0xB2, then fifo_data_ready=0 -> burst_valid after 4 idle cycles with data=0x0000B2A1, mask=4'b0011, count=2.
- Flush: flush asserted on the same edge as the 3rd accept (0x11,0x22,0x33) -> data=0x00332211, mask=4'b0111, count=3.
- Flush with count=0 -> no burst_valid and no state change. A subsequent word lands in lane 0.
- Reset: assert reset in HOLD holding 0x44332211 -> burst_valid=0 and outputs 0 without waiting for a clock edge. After release, push 0x55 and flush -> data=0x00000055, mask=4'b0001.
